// File: rtl/stos_ster_pkg.sv
// Shared types for the stack sequencer: FSM states and stack source select.
package stos_ster_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAPT,
    ERR
  } st_t;

  localparam logic ST_MUX_PC  = 1'b1;
  localparam logic ST_MUX_ACC = 1'b0;

endpackage

// File: rtl/stos_ster.sv
// Stack sequencer: turns call/ret/push/pop requests into stack strobes.
// Define STOS_STER_ERR_EN to trap overflow/underflow in a sticky ERR state.
module stos_ster
  import stos_ster_pkg::*;
#(
  parameter int STOS_data_rozm = 8,
  parameter int STOS_Rozm      = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_call,
  input  logic                      req_ret,
  input  logic                      req_push,
  input  logic                      req_pop,
  output logic                      ready,
  output logic                      done,
  output logic                      st_push,
  output logic                      st_pop,
  output logic                      st_mux,
  input  logic [STOS_data_rozm-1:0] st_data_out,
  input  logic                      st_full,
  input  logic                      st_empty,
  output logic                      pc_load,
  output logic                      acc_load,
  output logic [STOS_data_rozm-1:0] ld_data,
  output logic                      err,
  input  logic                      clr_err
);

  st_t  state;
  logic op_pc;

  // A zero-depth stack can never accept or return a word.
  localparam logic NO_DEPTH = (STOS_Rozm < 1);

  logic wr_req;
  logic rd_req;
  logic ovf;
  logic unf;

  assign wr_req = req_call | req_push;
  assign rd_req = ~wr_req & (req_ret | req_pop);
  assign ovf    = st_full | NO_DEPTH;
  assign unf    = st_empty | NO_DEPTH;
  assign ready  = (state == IDLE);

`ifdef STOS_STER_ERR_EN
  assign err = (state == ERR);
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_pc    <= 1'b0;
      done     <= 1'b0;
      st_push  <= 1'b0;
      st_pop   <= 1'b0;
      st_mux   <= ST_MUX_ACC;
      pc_load  <= 1'b0;
      acc_load <= 1'b0;
      ld_data  <= '0;
    end else begin
      done     <= 1'b0;
      st_push  <= 1'b0;
      st_pop   <= 1'b0;
      pc_load  <= 1'b0;
      acc_load <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            wr_req: begin
              op_pc <= req_call;
              if (ovf) begin
                done <= 1'b1;
`ifdef STOS_STER_ERR_EN
                state <= ERR;
`endif
              end else begin
                state   <= WR;
                st_push <= 1'b1;
                st_mux  <= req_call ? ST_MUX_PC
                                    : ST_MUX_ACC;
              end
            end
            rd_req: begin
              op_pc <= req_ret;
              if (unf) begin
                done <= 1'b1;
`ifdef STOS_STER_ERR_EN
                state <= ERR;
`endif
              end else begin
                state  <= RD;
                st_pop <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
        WR: begin
          state  <= IDLE;
          done   <= 1'b1;
          st_mux <= ST_MUX_ACC;
        end
        RD: state <= CAPT;
        CAPT: begin
          state    <= IDLE;
          done     <= 1'b1;
          ld_data  <= st_data_out;
          pc_load  <= op_pc;
          acc_load <= ~op_pc;
        end
`ifdef STOS_STER_ERR_EN
        ERR: if (clr_err) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stos_ster.sv
// Bench for stos_ster: stack plant, queue reference model, random ops.
// Expectations follow STOS_STER_ERR_EN when it is defined for the build.
module tb_stos_ster;

  localparam int W     = 8;
  localparam int DEPTH = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_call = 1'b0;
  logic         req_ret = 1'b0;
  logic         req_push = 1'b0;
  logic         req_pop = 1'b0;
  logic         ready;
  logic         done;
  logic         st_push;
  logic         st_pop;
  logic         st_mux;
  logic [W-1:0] st_data_out = '0;
  logic         st_full = 1'b0;
  logic         st_empty = 1'b1;
  logic         pc_load;
  logic         acc_load;
  logic [W-1:0] ld_data;
  logic         err;
  logic         clr_err = 1'b0;

  logic [W-1:0] pc_val = '0;
  logic [W-1:0] acc_val = '0;

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] stk[$];
  logic [W-1:0] mdl[$];
  logic [W-1:0] last_ld = '0;

  stos_ster #(
    .STOS_data_rozm(W),
    .STOS_Rozm(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_call(req_call),
    .req_ret(req_ret),
    .req_push(req_push),
    .req_pop(req_pop),
    .ready(ready),
    .done(done),
    .st_push(st_push),
    .st_pop(st_pop),
    .st_mux(st_mux),
    .st_data_out(st_data_out),
    .st_full(st_full),
    .st_empty(st_empty),
    .pc_load(pc_load),
    .acc_load(acc_load),
    .ld_data(ld_data),
    .err(err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Stack plant with a registered read port.
  always @(posedge clk) begin
    if (st_push) stk.push_back(st_mux ? pc_val : acc_val);
    if (st_pop && stk.size() > 0) st_data_out <= stk.pop_back();
    st_full  <= (stk.size() >= DEPTH);
    st_empty <= (stk.size() == 0);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic obs(output int lat, output int np, output int npop,
                     output int npc, output int nacc, output logic mux,
                     output logic [W-1:0] ld, output bit both);
    lat = 0; np = 0; npop = 0; npc = 0; nacc = 0;
    mux = 1'b0; ld = '0; both = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (st_push) begin np++; mux = st_mux; end
      if (st_pop) npop++;
      if (st_push && st_pop) both = 1'b1;
      if (pc_load) begin npc++; ld = ld_data; end
      if (acc_load) begin nacc++; ld = ld_data; end
      if (done) begin lat = c; break; end
    end
  endtask

  // k: 0 call, 1 ret, 2 push, 3 pop
  task automatic predict(input int k, input logic [W-1:0] v,
                         output int lat, output int np, output int npop,
                         output int npc, output int nacc,
                         output logic [W-1:0] eld, output bit flt);
    np = 0; npop = 0; npc = 0; nacc = 0; eld = last_ld; flt = 1'b0;
    if (k == 0 || k == 2) begin
      if (mdl.size() >= DEPTH) begin flt = 1'b1; lat = 1; end
      else begin lat = 2; np = 1; mdl.push_back(v); end
    end else begin
      if (mdl.size() == 0) begin flt = 1'b1; lat = 1; end
      else begin
        lat = 3; npop = 1; eld = mdl.pop_back();
        if (k == 1) npc = 1; else nacc = 1;
      end
    end
  endtask

  task automatic fault_chk(input string nm, input bit flt);
`ifdef STOS_STER_ERR_EN
    if (flt) begin
      chk({nm, ".err"}, int'(err), 1);
      chk({nm, ".rdy0"}, int'(ready), 0);
      @(negedge clk);
      chk({nm, ".hold"}, int'(ready), 0);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk({nm, ".clr"}, int'(err), 0);
    end
`else
    if (flt) chk({nm, ".err"}, int'(err), 0);
`endif
    chk({nm, ".rdy"}, int'(ready), 1);
  endtask

  task automatic op(input int k, input logic [W-1:0] v, input string nm);
    int el, enp, enpop, enpc, enacc;
    int l, p, pp, pcl, accl;
    logic [W-1:0] eld, ld;
    logic mux;
    bit flt, both;
    predict(k, v, el, enp, enpop, enpc, enacc, eld, flt);
    pc_val   = (k == 0) ? v : ~v;
    acc_val  = (k == 2) ? v : ~v;
    req_call = (k == 0);
    req_ret  = (k == 1);
    req_push = (k == 2);
    req_pop  = (k == 3);
    obs(l, p, pp, pcl, accl, mux, ld, both);
    req_call = 1'b0; req_ret = 1'b0;
    req_push = 1'b0; req_pop = 1'b0;
    chk({nm, ".lat"}, l, el);
    chk({nm, ".push"}, p, enp);
    chk({nm, ".pop"}, pp, enpop);
    chk({nm, ".pcl"}, pcl, enpc);
    chk({nm, ".accl"}, accl, enacc);
    chk({nm, ".both"}, int'(both), 0);
    if (enp == 1) chk({nm, ".mux"}, int'(mux), (k == 0) ? 1 : 0);
    if (enpc + enacc == 1) chk({nm, ".ld"}, int'(ld), int'(eld));
    last_ld = eld;
    chk({nm, ".hold"}, int'(ld_data), int'(last_ld));
    fault_chk(nm, flt);
  endtask

  initial begin
    int el, enp, enpop, enpc, enacc, l, p, pp, pcl, accl, nd;
    logic [W-1:0] eld, ld;
    logic mux;
    bit flt, both;

    #2;
    chk("rst.ready", int'(ready), 1);
    chk("rst.done", int'(done), 0);
    chk("rst.push", int'(st_push), 0);
    chk("rst.pop", int'(st_pop), 0);
    chk("rst.mux", int'(st_mux), 0);
    chk("rst.pcl", int'(pc_load), 0);
    chk("rst.accl", int'(acc_load), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.ld", int'(ld_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    op(0, 8'hBB, "call_bb");
    op(1, 8'h00, "ret_bb");

    op(2, 8'h0A, "push_0a");
    op(2, 8'h0B, "push_0b");
    op(2, 8'h0C, "push_0c");
    op(3, 8'h00, "pop_0c");
    op(3, 8'h00, "pop_0b");
    op(3, 8'h00, "pop_0a");

    predict(0, 8'h55, el, enp, enpop, enpc, enacc, eld, flt);
    pc_val = 8'h55; acc_val = 8'h66;
    req_call = 1'b1; req_pop = 1'b1;
    obs(l, p, pp, pcl, accl, mux, ld, both);
    req_call = 1'b0;
    chk("prio.lat1", l, 2);
    chk("prio.push", p, 1);
    chk("prio.mux", int'(mux), 1);
    chk("prio.nopop", pp, 0);
    predict(3, 8'h00, el, enp, enpop, enpc, enacc, eld, flt);
    obs(l, p, pp, pcl, accl, mux, ld, both);
    req_pop = 1'b0;
    chk("prio.lat2", l, el);
    chk("prio.accl", accl, 1);
    chk("prio.ld", int'(ld), int'(eld));
    last_ld = eld;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("prio.ndone", nd, 0);

    for (int i = 0; i < DEPTH; i++) op(2, W'(i + 1), "fill");
    op(2, 8'hEE, "ovf");
    op(0, 8'hEF, "ovf_call");
    for (int i = 0; i < DEPTH; i++) op(3, 8'h00, "drain");
    op(1, 8'h00, "unf_ret");
    op(3, 8'h00, "unf_pop");

    op(2, 8'h77, "pre_rd");
    @(negedge clk);
    req_ret = 1'b1;
    @(negedge clk);
    chk("rrd.inrd", int'(st_pop), 1);
    #2 rst = 1'b1;
    #1;
    chk("rrd.pop0", int'(st_pop), 0);
    chk("rrd.ready", int'(ready), 1);
    chk("rrd.ld0", int'(ld_data), 0);
    req_ret = 1'b0;
    last_ld = '0;
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || pc_load || acc_load) nd++;
    end
    chk("rrd.quiet", nd, 0);

    for (int i = 0; i < 80; i++)
      op(int'($urandom_range(0, 3)), W'($urandom), "rnd");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
